// File: rtl/program_loader.sv
// Boot-time instruction loader. Receives a length-prefixed byte image, packs little-endian
// 32-bit words into instruction memory, checks an XOR checksum, and holds the core in reset
// until a complete, checksum-clean image is in place.
module program_loader #(
  parameter int unsigned MaxWords = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        start_i,
  output logic        im_wr_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_count_o
);

  localparam logic [15:0] MaxLen = 16'(MaxWords);

  typedef enum logic [2:0] {StLenLo, StLenHi, StData, StCsum, StDone, StError} state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] word_count_q, word_count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;       // bytes 0..2 of the word in flight; byte 3 comes off the wire
  logic [7:0]  csum_q, csum_d;
  logic        im_wr_q, im_wr_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_data_q, im_data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        rx_ready;
  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = rx_valid_i && rx_ready;
  assign len_full  = {rx_data_i, len_lo_q};
  assign last_word = (word_idx_q + 16'd1) == word_count_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StLenLo;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: begin
        if (accept) begin
          if (len_full > MaxLen)   state_d = StError;
          else if (len_full == '0) state_d = StCsum;
          else                     state_d = StData;
        end
      end
      StData:  if (accept && byte_idx_q == 2'd3 && last_word) state_d = StCsum;
      StCsum:  if (accept) state_d = (rx_data_i == csum_q) ? StDone : StError;
      StDone, StError: if (start_i) state_d = StLenLo;
      default: state_d = StLenLo;
    endcase
  end

  // FSM outputs: bytes are only taken while an image is being received
  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StCsum: rx_ready = 1'b1;
      default:                          rx_ready = 1'b0;
    endcase
  end

  // Datapath next-state: header capture, word assembly, checksum and status flags
  always_comb begin
    len_lo_d     = len_lo_q;
    word_count_d = word_count_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    im_wr_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_data_d    = im_data_q;
    cpu_rst_d    = cpu_rst_q;
    done_d       = done_q;
    err_d        = err_q;
    unique case (state_q)
      StLenLo: if (accept) len_lo_d = rx_data_i;
      StLenHi: begin
        if (accept) begin
          word_count_d = len_full;
          if (len_full > MaxLen) err_d = 1'b1;
        end
      end
      StData: begin
        if (accept) begin
          csum_d     = csum_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = rx_data_i;
            2'd1: asm_d[15:8]  = rx_data_i;
            2'd2: asm_d[23:16] = rx_data_i;
            2'd3: begin
              im_data_d  = {rx_data_i, asm_q};
              im_addr_d  = {14'd0, word_idx_q, 2'b00};
              im_wr_d    = 1'b1;
              word_idx_d = word_idx_q + 16'd1;
            end
            default: ;
          endcase
        end
      end
      StCsum: begin
        if (accept) begin
          if (rx_data_i == csum_q) begin
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDone, StError: begin
        if (start_i) begin
          word_idx_d = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          csum_d     = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_rst_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_lo_q     <= '0;
      word_count_q <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      im_wr_q      <= 1'b0;
      im_addr_q    <= '0;
      im_data_q    <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      len_lo_q     <= len_lo_d;
      word_count_q <= word_count_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      im_wr_q      <= im_wr_d;
      im_addr_q    <= im_addr_d;
      im_data_q    <= im_data_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready_o   = rx_ready;
  assign im_wr_o      = im_wr_q;
  assign im_addr_o    = im_addr_q;
  assign im_data_o    = im_data_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_count_o = word_count_q;

endmodule
